// File: rtl/alu_result_tx_if.sv
// Handshake and serial-line bundle between the ALU output stage and the serial transmitter.
// The ALU side is the master: it raises tx_start with tx_data and watches tx, tx_busy and tx_done.
interface alu_result_tx_if #(
   parameter int NBITS = 8
);
   logic             tx_start;
   logic [NBITS-1:0] tx_data;
   logic             tx;
   logic             tx_busy;
   logic             tx_done;

   modport master (
      output tx_start, tx_data,
      input  tx, tx_busy, tx_done
   );

   modport slave (
      input  tx_start, tx_data,
      output tx, tx_busy, tx_done
   );
endinterface

// File: rtl/alu_result_tx.sv
// Asynchronous serial transmitter for ALU results: start bit, NBITS data bits LSB first, one stop bit.
// All outputs come straight from flops so the line never glitches.
module alu_result_tx #(
   parameter int NBITS        = 8,
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic           clk,
   input  logic           btn_Reset,
   alu_result_tx_if.slave bus
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [IDX_W-1:0] idx_q,   idx_d;
   logic [NBITS-1:0] shift_q, shift_d;
   logic             tx_q,    tx_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;

   logic             bit_end;
   logic [NBITS-1:0] shift_nx;

   assign bit_end  = (cnt_q == CNT_LAST);
   assign shift_nx = shift_q >> 1;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
      state_d = state_q;
      cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            cnt_d  = '0;
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (bus.tx_start) begin
               shift_d = bus.tx_data;
               idx_d   = '0;
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_nx;
               idx_d   = idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  tx_d    = shift_nx[0];
               end
            end
         end
         STOP: begin
            // Done and busy-drop land on the same edge as the return to IDLE.
            if (bit_end) begin
               state_d = IDLE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge btn_Reset) begin
      if (btn_Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.tx      = tx_q;
   assign bus.tx_busy = busy_q;
   assign bus.tx_done = done_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Scoreboard bench for alu_result_tx: stimulus queues expected frames, a line monitor decodes and compares.
module tb_alu_result_tx;
   localparam int NBITS = 8;
   localparam int CPB   = 4;
   localparam int FRAME = (NBITS + 2) * CPB;

   typedef struct packed {
      logic [7:0] data;
      logic       abort;
   } exp_t;

   logic clk       = 1'b0;
   logic btn_Reset = 1'b0;
   always #5 clk = ~clk;

   alu_result_tx_if #(.NBITS(NBITS)) bus ();

   alu_result_tx #(.NBITS(NBITS), .CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .btn_Reset (btn_Reset),
      .bus       (bus)
   );

   exp_t exp_q[$];
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   cyc       = 0;
   int   done_cnt  = 0;
   int   frame_cnt = 0;
   int   start_cyc = 0;
   int   prev_start_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.tx_done === 1'b1) done_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference line level for cycle c of a frame carrying d.
   function automatic logic lvl(input logic [7:0] d, input int c);
      int j;
      j = c / CPB;
      if (j == 0) return 1'b0;
      if (j <= NBITS) return d[j-1];
      return 1'b1;
   endfunction

   // Monitor: detect a start edge on the line, then compare every cycle of the frame.
   initial begin : monitor
      logic       prev_tx;
      exp_t       e;
      int         bad;
      bit         aborted;
      logic [7:0] got;
      prev_tx = 1'bx;
      forever begin
         @(negedge clk);
         if (btn_Reset !== 1'b1 && bus.tx === 1'b0 && prev_tx === 1'b1) begin
            frame_cnt++;
            prev_start_cyc = start_cyc;
            start_cyc      = cyc;
            bad     = 0;
            aborted = 1'b0;
            got     = '0;
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) e = exp_q.pop_front();
            else e = '{data: 8'h00, abort: 1'b0};
            for (int c = 0; c < FRAME; c++) begin
               if (c > 0) @(negedge clk);
               if (btn_Reset === 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (bus.tx !== lvl(e.data, c) || bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) bad++;
               if (c >= CPB && c < (NBITS + 1) * CPB && (c % CPB) == CPB / 2) got[c/CPB-1] = bus.tx;
            end
            check("frame_abort", 32'(aborted), 32'(e.abort));
            if (!aborted) begin
               check("frame_bad_cycles", bad, 0);
               check("frame_data", 32'(got), 32'(e.data));
               @(negedge clk);
               check("done_at_end_done_busy_tx", 32'({bus.tx_done, bus.tx_busy, bus.tx}), 32'b101);
            end
            prev_tx = bus.tx;
         end else begin
            prev_tx = bus.tx;
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d);
      bus.tx_data  = d;
      bus.tx_start = 1'b1;
      tick();
      bus.tx_start = 1'b0;
      check("start_latency_tx_busy", 32'({bus.tx, bus.tx_busy}), 32'b01);
   endtask

   initial begin : stimulus
      int d0;
      int f0;
      bus.tx_start = 1'b0;
      bus.tx_data  = '0;
      tick(2);

      // Asynchronous reset, with a simultaneous request that must be ignored.
      #2 btn_Reset = 1'b1;
      #1 check("reset_async_tx_busy_done", 32'({bus.tx, bus.tx_busy, bus.tx_done}), 32'b100);
      bus.tx_start = 1'b1;
      bus.tx_data  = 8'h77;
      tick(2);
      check("reset_held_tx_busy_done", 32'({bus.tx, bus.tx_busy, bus.tx_done}), 32'b100);
      bus.tx_start = 1'b0;
      @(negedge clk);
      #2 btn_Reset = 1'b0;
      tick(2);
      check("no_frame_during_reset", frame_cnt, 0);

      // Single frame.
      exp_q.push_back('{data: 8'hA5, abort: 1'b0});
      d0 = done_cnt;
      send(8'hA5);
      tick(FRAME + 2);
      check("single_done_pulses", done_cnt - d0, 1);

      // Request during a frame is ignored.
      exp_q.push_back('{data: 8'hA5, abort: 1'b0});
      d0 = done_cnt;
      f0 = frame_cnt;
      send(8'hA5);
      tick(16);
      bus.tx_data  = 8'h3C;
      bus.tx_start = 1'b1;
      tick();
      bus.tx_start = 1'b0;
      tick(FRAME);
      check("busy_reject_done_pulses", done_cnt - d0, 1);
      check("busy_reject_frames", frame_cnt - f0, 1);

      // Back-to-back with tx_start held high.
      exp_q.push_back('{data: 8'h00, abort: 1'b0});
      exp_q.push_back('{data: 8'hFF, abort: 1'b0});
      d0 = done_cnt;
      bus.tx_data  = 8'h00;
      bus.tx_start = 1'b1;
      tick();
      check("b2b_first_start", 32'({bus.tx, bus.tx_busy}), 32'b01);
      bus.tx_data = 8'hFF;
      tick(FRAME);
      check("b2b_done_cycle_done_busy_tx", 32'({bus.tx_done, bus.tx_busy, bus.tx}), 32'b101);
      tick();
      bus.tx_start = 1'b0;
      check("b2b_second_start", 32'({bus.tx, bus.tx_busy, bus.tx_done}), 32'b010);
      tick(FRAME + 2);
      check("b2b_period", start_cyc - prev_start_cyc, FRAME + 1);
      check("b2b_done_pulses", done_cnt - d0, 2);

      // Reset during data bit 4, then a clean retry.
      exp_q.push_back('{data: 8'h5A, abort: 1'b1});
      d0 = done_cnt;
      send(8'h5A);
      tick(20);
      #1 btn_Reset = 1'b1;
      #1 check("midframe_reset_tx_busy_done", 32'({bus.tx, bus.tx_busy, bus.tx_done}), 32'b100);
      tick();
      @(negedge clk);
      #1 btn_Reset = 1'b0;
      tick(FRAME + 2);
      check("midframe_reset_no_done", done_cnt - d0, 0);
      exp_q.push_back('{data: 8'h5A, abort: 1'b0});
      d0 = done_cnt;
      send(8'h5A);
      tick(FRAME + 2);
      check("retry_done_pulses", done_cnt - d0, 1);

      // Input isolation: tx_data churns throughout the frame.
      exp_q.push_back('{data: 8'hC3, abort: 1'b0});
      d0 = done_cnt;
      send(8'hC3);
      for (int i = 0; i < FRAME; i++) begin
         bus.tx_data = 8'(i * 37 + 5);
         tick();
      end
      tick(3);
      check("isolation_done_pulses", done_cnt - d0, 1);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_result_tx.md
# alu_result_tx

Serial transmitter that sends ALU results off-board. It accepts an NBITS-wide result word on a one-cycle start request and shifts it out as an asynchronous serial frame: start bit, NBITS data bits LSB first, one stop bit, no parity. It sits on the output side of the ALU top level, opposite the operand/opcode loading path, and gives the host a readable copy of the ALU output.

## Interface

Parameters:
- NBITS, 8, data bits per frame; equals the ALU result width.
- CLKS_PER_BIT, 5208, clk cycles per serial bit (50 MHz / 9600 baud); legal range ≥ 2.

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- btn_Reset  input  1  reset; one clock, asynchronous, active-high.
- tx_start  input  1  transmit request; sampled on the rising edge of clk.
- tx_data  input  NBITS  word to send; captured on the edge where tx_start is accepted.
- tx  output  1  serial line; idles high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when the stop bit completes.

## Operation

- States: IDLE, START, DATA, STOP. Encoding is free.
- Internal registers:
  - shift register, NBITS wide.
  - bit-time counter, $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1.
  - bit index, $clog2(NBITS) bits, counts 0..NBITS-1.
- IDLE: tx=1, tx_busy=0. If tx_start=1, latch tx_data into the shift register, clear the counter and the bit index, and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx drives the current LSB of the shift register for CLKS_PER_BIT cycles per bit.
  - At each bit end, shift right and increment the bit index.
  - After bit NBITS-1, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - At the end, assert tx_done for one cycle, return to IDLE and drop tx_busy on that same edge.
- tx_start outside IDLE is ignored. The latched word is not disturbed by tx_data changes mid-frame.
- tx, tx_busy and tx_done are driven directly from registers, so the line is glitch-free.
- Counter wrap: the counter resets to 0 at CLKS_PER_BIT-1. It never exceeds that value.
- Reset is asynchronous and may occur at any point, including mid-frame. It forces:
  - state IDLE
  - tx=1
  - tx_busy=0
  - tx_done=0
  - counter, bit index and shift register all 0
- The first request after reset release is accepted normally.

## Timing

- Reset values: tx=1, tx_busy=0, tx_done=0.
- Accept edge: the edge where tx_start=1 in IDLE. Call it edge 0.
- Edge 0 → tx=0 and tx_busy=1, visible right after edge 0. Latency is one cycle from request to the start-bit leading edge.
- Data bit k occupies cycles [(1+k)·CLKS_PER_BIT, (2+k)·CLKS_PER_BIT) after edge 0.
- The stop bit occupies the next CLKS_PER_BIT cycles.
- tx_done=1 for exactly one cycle, starting at edge (NBITS+2)·CLKS_PER_BIT. On that edge, tx_busy also falls to 0 and the state returns to IDLE.
- Back-to-back: if tx_start is high during the tx_done cycle, it is accepted on the next edge. The line is then high for exactly one extra cycle between frames. Total period is (NBITS+2)·CLKS_PER_BIT+1 cycles.
- Simultaneous tx_start and btn_Reset: reset wins and no frame starts.

## Test plan

All scenarios use NBITS=8 and CLKS_PER_BIT=4.

- Reset check: assert btn_Reset asynchronously between clock edges → tx=1, tx_busy=0, tx_done=0 immediately, and held while reset is high.
- Single frame: tx_data=0xA5 with a 1-cycle tx_start → tx is 0, 1,0,1,0,0,1,0,1, 1, each level held 4 cycles. tx_busy is high for 40 cycles. tx_done pulses once, at edge 40 after acceptance.
- Busy rejection: during the 0xA5 frame, pulse tx_start with tx_data=0x3C at bit 3 → the frame is still 0xA5, no second frame follows, and tx_done pulses exactly once.
- Back-to-back: hold tx_start high with tx_data=0x00, then 0xFF → frames 0x00 and 0xFF with exactly 1 idle-high cycle between them. Frame period is 41 cycles, and there are two tx_done pulses.
- Mid-frame reset: pulse btn_Reset during data bit 4 of 0x5A → tx=1 and tx_busy=0 without waiting for a clock edge, and no tx_done. A subsequent 0x5A request produces a complete, correct 40-cycle frame.
- Input isolation: change tx_data every cycle during a 0xC3 frame → the serialized bits match 0xC3 LSB first (1,1,0,0,0,0,1,1).
